// File: rtl/pio_bus_master.sv
// Avalon-MM initiator issuing one read/write at a time to 2-bit-addressed PIO slaves.
// Optional waitrequest timeout enabled by defining PIO_MASTER_TIMEOUT_EN.
module pio_bus_master #(
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned LAT_W = 2;
  localparam int unsigned TO_W  = 16;

  if (READ_LATENCY < 1 || READ_LATENCY > 4 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("pio_bus_master: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic              wr_q, wr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              cmd_ready_nxt;
  logic              rsp_valid_nxt;
  logic              cs_nxt;
  logic              write_n_nxt;

`ifdef PIO_MASTER_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            err_q, err_nxt;
  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

  // State and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      wr_q           <= 1'b0;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_readdata   <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
`ifdef PIO_MASTER_TIMEOUT_EN
      to_cnt         <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      lat_cnt        <= lat_cnt_nxt;
      wr_q           <= wr_nxt;
      cmd_ready      <= cmd_ready_nxt;
      rsp_valid      <= rsp_valid_nxt;
      rsp_readdata   <= rdata_nxt;
      avm_chipselect <= cs_nxt;
      avm_write_n    <= write_n_nxt;
      avm_address    <= addr_nxt;
      avm_writedata  <= wdata_nxt;
`ifdef PIO_MASTER_TIMEOUT_EN
      to_cnt         <= to_cnt_nxt;
      err_q          <= err_nxt;
`endif
    end
  end

  // Next-state and next-output decode; outputs follow the state being entered
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    wr_nxt      = wr_q;
    addr_nxt    = avm_address;
    wdata_nxt   = avm_writedata;
    rdata_nxt   = rsp_readdata;
`ifdef PIO_MASTER_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
    err_nxt     = err_q;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wr_nxt    = cmd_write;
          addr_nxt  = cmd_address;
          wdata_nxt = cmd_writedata;
          state_nxt = ISSUE;
`ifdef PIO_MASTER_TIMEOUT_EN
          to_cnt_nxt = '0;
          err_nxt    = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          if (wr_q) begin
            rdata_nxt = '0;
            state_nxt = RESP;
          end else begin
            lat_cnt_nxt = LAT_W'(READ_LATENCY - 1);
            state_nxt   = WAIT;
          end
        end
`ifdef PIO_MASTER_TIMEOUT_EN
        // Stall limit reached with waitrequest still high: abandon the transfer
        else if (to_cnt == TO_LIMIT) begin
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
`endif
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          rdata_nxt = avm_readdata;
          state_nxt = RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
    rsp_valid_nxt = (state_nxt == RESP);
    cs_nxt        = (state_nxt == ISSUE);
    write_n_nxt   = !((state_nxt == ISSUE) && wr_nxt);
  end

endmodule

// File: tb/tb_pio_bus_master.sv
// Bench for pio_bus_master: transaction-level model checked every cycle plus directed latency/data checks.
module tb_pio_bus_master;

  localparam int unsigned TO = 8;
  localparam int unsigned RL = 1;
`ifdef PIO_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  int cs_cnt = 0;

  always #5 clk = ~clk;

  pio_bus_master #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  // PIO-like slave: registered readdata one cycle after an accepted read
  logic [31:0] slv_mem [4] = '{32'hA5A5_1234, 32'h0, 32'h0, 32'h0};
  always @(posedge clk) begin
    if (avm_chipselect && !avm_waitrequest) begin
      if (!avm_write_n) slv_mem[avm_address] <= avm_writedata;
      else              avm_readdata <= slv_mem[avm_address];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus and when the response is due
  logic [31:0] m_mem [4] = '{32'hA5A5_1234, 32'h0, 32'h0, 32'h0};
  bit          m_rdy, m_rv, m_err, m_cs, m_wn, m_wr;
  logic [1:0]  m_addr;
  logic [31:0] m_wd, m_rd;
  int          m_stall, m_wait;

  always @(posedge clk) begin
    if (reset) begin
      m_rdy = 0; m_rv = 0; m_err = 0; m_cs = 0; m_wn = 1; m_wr = 0;
      m_addr = 0; m_wd = 0; m_rd = 0; m_stall = 0; m_wait = 0;
    end else if (m_rdy) begin
      if (cmd_valid) begin
        m_rdy = 0; m_cs = 1; m_wr = cmd_write; m_wn = !cmd_write;
        m_addr = cmd_address; m_wd = cmd_writedata; m_stall = 0; m_err = 0;
      end
    end else if (m_cs) begin
      if (!avm_waitrequest) begin
        m_cs = 0; m_wn = 1;
        if (m_wr) begin
          m_mem[m_addr] = m_wd; m_rd = 0; m_rv = 1;
        end else begin
          m_wait = int'(RL);
        end
      end else begin
        m_stall++;
        if (TO_EN && m_stall == int'(TO)) begin
          m_cs = 0; m_wn = 1; m_rd = 0; m_err = 1; m_rv = 1;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_rd = m_mem[m_addr]; m_rv = 1;
      end
    end else if (m_rv) begin
      if (rsp_ready) begin
        m_rv = 0; m_rdy = 1;
      end
    end else begin
      m_rdy = 1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(m_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_readdata", rsp_readdata, m_rd);
      chk("rsp_error", 32'(rsp_error), 32'(m_err));
      chk("avm_chipselect", 32'(avm_chipselect), 32'(m_cs));
      chk("avm_write_n", 32'(avm_write_n), 32'(m_wn));
      chk("avm_address", 32'(avm_address), 32'(m_addr));
      chk("avm_writedata", avm_writedata, m_wd);
      if (avm_chipselect) cs_cnt++;
    end
  end

  task automatic do_cmd(input bit wr, input logic [1:0] a, input logic [31:0] d,
                        input int stall, input int hold,
                        output int lat, output logic [31:0] rd, output logic er);
    int k;
    lat = -1; rd = 32'hx; er = 1'bx;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1; cmd_write = wr; cmd_address = a; cmd_writedata = d;
    avm_waitrequest = (stall > 0);
    @(posedge clk);
    #1;
    cmd_valid = 0; cmd_writedata = $urandom; cmd_address = 2'($urandom); cs_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; rd = rsp_readdata; er = rsp_error;
        break;
      end
      avm_waitrequest = (c <= stall);
    end
    avm_waitrequest = 0;
    if (lat < 0) begin
      chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", rsp_readdata, rd);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          k;

  initial begin
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_address = 0; cmd_writedata = 0;
    rsp_ready = 0; avm_waitrequest = 0;
    @(posedge clk);
    started = 1;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_write_n", 32'(avm_write_n), 32'd1);
    chk("reset_chipselect", 32'(avm_chipselect), 32'd0);
    reset = 0;

    do_cmd(1'b1, 2'd1, 32'h0000_FFFF, 0, 0, lat, rd, er);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_readdata", rd, 32'h0);
    chk("wr_error", 32'(er), 32'd0);
    chk("wr_cs_cycles", 32'(cs_cnt), 32'd1);

    do_cmd(1'b0, 2'd0, 32'hDEAD_BEEF, 0, 0, lat, rd, er);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hA5A5_1234);
    chk("rd_cs_cycles", 32'(cs_cnt), 32'd1);

    do_cmd(1'b0, 2'd1, 32'h0, 0, 5, lat, rd, er);
    chk("hold_latency", 32'(lat), 32'd3);
    chk("hold_data", rd, 32'h0000_FFFF);

    do_cmd(1'b1, 2'd2, 32'h1234_5678, 3, 0, lat, rd, er);
    chk("stall_wr_latency", 32'(lat), 32'd5);
    chk("stall_wr_cs_cycles", 32'(cs_cnt), 32'd4);

    do_cmd(1'b0, 2'd2, 32'h0, 2, 0, lat, rd, er);
    chk("stall_rd_latency", 32'(lat), 32'd5);
    chk("stall_rd_data", rd, 32'h1234_5678);

    for (int i = 1; i <= 3; i++) begin
      do_cmd(1'b1, 2'(i), 32'h1111_1111 * 32'(i), 0, 0, lat, rd, er);
      chk("loop_wr_latency", 32'(lat), 32'd2);
    end
    for (int i = 3; i >= 1; i--) begin
      do_cmd(1'b0, 2'(i), 32'h0, 0, i - 1, lat, rd, er);
      chk("loop_rd_data", rd, 32'h1111_1111 * 32'(i));
    end

    // Reset while a read sits in its latency wait
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    cmd_valid = 1; cmd_write = 0; cmd_address = 2'd0;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_chipselect", 32'(avm_chipselect), 32'd0);
    chk("midrst_write_n", 32'(avm_write_n), 32'd1);
    chk("midrst_address", 32'(avm_address), 32'd0);
    chk("midrst_writedata", avm_writedata, 32'h0);
    chk("midrst_readdata", rsp_readdata, 32'h0);
    @(negedge clk);
    chk("midrst_rsp_valid2", 32'(rsp_valid), 32'd0);
    reset = 0;

    do_cmd(1'b0, 2'd0, 32'h0, 0, 0, lat, rd, er);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_data", rd, 32'hA5A5_1234);

`ifdef PIO_MASTER_TIMEOUT_EN
    do_cmd(1'b1, 2'd3, 32'hCAFE_0000, 100, 0, lat, rd, er);
    chk("to_latency", 32'(lat), 32'd9);
    chk("to_error", 32'(er), 32'd1);
    chk("to_readdata", rd, 32'h0);
    chk("to_cs_cycles", 32'(cs_cnt), 32'd8);
    do_cmd(1'b0, 2'd3, 32'h0, 0, 0, lat, rd, er);
    chk("to_after_data", rd, 32'h3333_3333);
    chk("to_after_error", 32'(er), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
